int_ctrl: RTL and testbench
===========================

// Module: int_ctrl
// PURPOSE
//  Vectored interrupt controller feeding the PC-select path of the single-cycle datapath.
//  - Captures rising edges on external IRQ lines and holds them pending.
//  - Masks and prioritises the pending requests.
//  - Presents one request plus a jump vector to the control unit.
//  - Tracks the in-service source until the control unit signals return-from-interrupt.
//  - Single nesting level only; the return address is pushed by the existing stack.
// PARAMETERS
//  NIRQ        4       number of interrupt sources (index 0 = highest priority)
//  AW          10      vector width; matches the PC width
//  VEC_BASE    10'h3C0 vector of source 0
//  VEC_STRIDE  8       address distance between consecutive vectors
// PORTS
//  clk         in   1         rising-edge clock
//  reset       in   1         asynchronous, active-low reset
//  irq         in   NIRQ      raw external requests, asynchronous, edge-triggered
//  ei          in   1         pulse from control unit: set global enable
//  di          in   1         pulse from control unit: clear global enable
//  mask_we     in   1         write mask register this cycle
//  mask_din    in   NIRQ      new mask value (1 = source enabled)
//  int_ack     in   1         control unit takes the interrupt (PC <- vec, push return address)
//  reti        in   1         control unit executes return-from-interrupt
//  int_req     out  1         request to control unit
//  vec         out  AW        target address of the requesting source
//  pending     out  NIRQ      captured, not yet acknowledged edges
//  in_service  out  NIRQ      one-hot source currently being serviced (0 = none)
//  ie          out  1         global interrupt enable
// BEHAVIOUR
//  Reset: reset low clears all state immediately, including mid-request or mid-service.
//   - int_req=0, vec=VEC_BASE, pending=0, in_service=0, ie=0, mask=0, FSM=IDLE.
//   - Synchroniser flops reset to 0, so an irq line already high at reset release counts as an edge.
//  Capture (per source i):
//   - 3-flop chain s1<=irq, s2<=s1, s3<=s2; rise = s2 & ~s3.
//   - pending[i] sets on the clock edge where rise[i]=1, i.e. on the 3rd rising clk edge after irq[i] is first sampled high.
//   - A level held high produces exactly one edge.
//   - An edge arriving on an already-pending source is merged, not counted.
//   - Set and clear of the same bit in one cycle: set wins, so the new edge is kept pending.
//  Enable/mask:
//   - ei sets ie; di clears ie; ei and di together: di wins.
//   - mask_we loads mask on the next edge.
//   - Effective request = ie & |(pending & mask).
//  FSM, registered outputs, 1-cycle latency:
//   - IDLE -> REQ when the effective request is true.
//     - Latch sel = lowest set index of (pending & mask).
//     - vec <= VEC_BASE + sel*VEC_STRIDE, computed modulo 2^AW.
//     - int_req=1 from the next cycle.
//   - REQ:
//     - sel and vec stay frozen; later mask or pending changes do not retarget the request.
//     - int_ack -> SERV: pending[sel] clears, in_service <= one-hot(sel), int_req=0 on the next cycle.
//     - di without int_ack -> IDLE; request is withdrawn (int_req=0), pending[sel] is kept.
//     - int_ack and di in the same cycle: int_ack wins.
//   - SERV:
//     - New edges accumulate in pending; no request is raised.
//     - reti -> IDLE and in_service clears.
//     - A new request can be raised at the earliest 1 cycle after returning to IDLE.
//   - int_ack outside REQ and reti outside SERV are ignored; no state change.
//  ie is never modified by the FSM; only ei, di and reset change it.
// TESTING (defaults)
//  1. Reset low mid-SERV
//     -> all outputs return to reset values asynchronously, before the next clk edge.
//  2. mask=4'b1111, ei; pulse irq[2] high for 1 cycle
//     -> pending=4'b0100 after 3 edges.
//     -> int_req=1 with vec=10'h3D0 one cycle later.
//     -> int_ack -> pending=0, in_service=4'b0100, int_req=0.
//  3. irq[3] and irq[1] rise together
//     -> vec=10'h3C8 (source 1).
//     -> after int_ack then reti, a second request with vec=10'h3D8 (source 3).
//  4. In SERV, irq[0] edge
//     -> pending[0]=1 but int_req stays 0 until reti.
//     -> int_req=1 with vec=10'h3C0 two cycles after reti.
//  5. In REQ, pulse di alone
//     -> int_req=0 and pending kept.
//     -> ei then re-raises the same vec.
//     -> di together with int_ack enters SERV.
//  6. mask=4'b0000 with irq[2] edge
//     -> pending=4'b0100, int_req=0.
//     -> mask_we with 4'b0100 -> int_req=1 two cycles after the mask write.

Source files
------------

// File: rtl/int_ctrl.sv
// Vectored interrupt controller: edge capture, mask/priority, single-level service tracking.
// Drives one registered request plus jump vector toward the control unit.
module int_ctrl #(
  parameter int              NIRQ       = 4,
  parameter int              AW         = 10,
  parameter logic [AW-1:0]   VEC_BASE   = 10'h3C0,
  parameter int              VEC_STRIDE = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NIRQ-1:0] i_irq,
  input  logic            i_ei,
  input  logic            i_di,
  input  logic            i_mask_we,
  input  logic [NIRQ-1:0] i_mask_din,
  input  logic            i_int_ack,
  input  logic            i_reti,
  output logic            o_int_req,
  output logic [AW-1:0]   o_vec,
  output logic [NIRQ-1:0] o_pending,
  output logic [NIRQ-1:0] o_in_service,
  output logic            o_ie
);

  localparam int SW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t          r_state;
  logic [NIRQ-1:0] r_s1, r_s2, r_s3;
  logic [NIRQ-1:0] r_pending;
  logic [NIRQ-1:0] r_mask;
  logic            r_ie;
  logic [SW-1:0]   r_sel;
  logic [AW-1:0]   r_vec;
  logic            r_int_req;
  logic [NIRQ-1:0] r_in_service;

  state_t          w_state_next;
  logic [NIRQ-1:0] w_rise;
  logic [NIRQ-1:0] w_masked;
  logic            w_eff_req;
  logic [SW-1:0]   w_sel_find;
  logic [NIRQ-1:0] w_sel_onehot;
  logic [NIRQ-1:0] w_clr;
  logic [SW-1:0]   w_sel_next;
  logic [AW-1:0]   w_vec_next;
  logic            w_int_req_next;
  logic [NIRQ-1:0] w_in_service_next;

  assign w_rise       = r_s2 & ~r_s3;
  assign w_masked     = r_pending & r_mask;
  assign w_eff_req    = r_ie & (|w_masked);
  assign w_sel_onehot = NIRQ'(1) << r_sel;

  // Synchroniser chain, pending capture (set beats clear), enable and mask.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_s3      <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_ie      <= 1'b0;
    end else begin
      r_s1      <= i_irq;
      r_s2      <= r_s1;
      r_s3      <= r_s2;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (i_mask_we) r_mask <= i_mask_din;
      if (i_di)      r_ie   <= 1'b0;
      else if (i_ei) r_ie   <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_vec        <= VEC_BASE;
      r_int_req    <= 1'b0;
      r_in_service <= '0;
    end else begin
      r_state      <= w_state_next;
      r_sel        <= w_sel_next;
      r_vec        <= w_vec_next;
      r_int_req    <= w_int_req_next;
      r_in_service <= w_in_service_next;
    end
  end

  always_comb begin
    w_sel_find = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (w_masked[i]) w_sel_find = SW'(i);
    end
  end

  // sel and vec are only reloaded when leaving IDLE, so a live request never retargets.
  always_comb begin
    w_state_next      = r_state;
    w_sel_next        = r_sel;
    w_vec_next        = r_vec;
    w_int_req_next    = r_int_req;
    w_in_service_next = r_in_service;
    w_clr             = '0;
    case (r_state)
      IDLE: begin
        if (w_eff_req) begin
          w_state_next   = REQ;
          w_sel_next     = w_sel_find;
          w_vec_next     = VEC_BASE + (AW'(w_sel_find) * AW'(VEC_STRIDE));
          w_int_req_next = 1'b1;
        end
      end
      REQ: begin
        if (i_int_ack) begin
          w_state_next      = SERV;
          w_int_req_next    = 1'b0;
          w_in_service_next = w_sel_onehot;
          w_clr             = w_sel_onehot;
        end else if (i_di) begin
          w_state_next   = IDLE;
          w_int_req_next = 1'b0;
        end
      end
      SERV: begin
        if (i_reti) begin
          w_state_next      = IDLE;
          w_in_service_next = '0;
        end
      end
      default: begin
        w_state_next   = IDLE;
        w_int_req_next = 1'b0;
      end
    endcase
  end

  assign o_int_req    = r_int_req;
  assign o_vec        = r_vec;
  assign o_pending    = r_pending;
  assign o_in_service = r_in_service;
  assign o_ie         = r_ie;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl: capture latency, priority, masking,
// withdrawal, service nesting and asynchronous reset.
module tb_int_ctrl;

  logic       clk;
  logic       rstN;
  logic [3:0] irq;
  logic       ei, di, maskWe, intAck, reti;
  logic [3:0] maskDin;
  logic       intReq;
  logic [9:0] vec;
  logic [3:0] pending, inService;
  logic       ie;

  int passCount  = 0;
  int checkCount = 0;

  int_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_irq       (irq),
    .i_ei        (ei),
    .i_di        (di),
    .i_mask_we   (maskWe),
    .i_mask_din  (maskDin),
    .i_int_ack   (intAck),
    .i_reti      (reti),
    .o_int_req   (intReq),
    .o_vec       (vec),
    .o_pending   (pending),
    .o_in_service(inService),
    .o_ie        (ie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change and outputs are sampled on falling edges only.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseAck();
    intAck = 1'b1; cycles(1); intAck = 1'b0;
  endtask

  task automatic pulseReti();
    reti = 1'b1; cycles(1); reti = 1'b0;
  endtask

  task automatic pulseIrq(input logic [3:0] lines);
    irq = lines; cycles(1); irq = 4'b0000;
  endtask

  task automatic test_reset();
    checkCount++; if (intReq !== 1'b0) $display("[TB] FAIL rst_int_req: got %b want 0", intReq); else passCount++;
    checkCount++; if (vec !== 10'h3C0) $display("[TB] FAIL rst_vec: got %h want 3c0", vec); else passCount++;
    checkCount++; if (pending !== 4'b0000) $display("[TB] FAIL rst_pending: got %b want 0000", pending); else passCount++;
    checkCount++; if (inService !== 4'b0000) $display("[TB] FAIL rst_in_service: got %b want 0000", inService); else passCount++;
    checkCount++; if (ie !== 1'b0) $display("[TB] FAIL rst_ie: got %b want 0", ie); else passCount++;
  endtask

  task automatic test_single();
    maskWe = 1'b1; maskDin = 4'b1111; ei = 1'b1;
    cycles(1);
    maskWe = 1'b0; ei = 1'b0;
    checkCount++; if (ie !== 1'b1) $display("[TB] FAIL single_ie: got %b want 1", ie); else passCount++;
    pulseIrq(4'b0100);
    cycles(1);
    checkCount++; if (pending !== 4'b0000) $display("[TB] FAIL single_pending_early: got %b want 0000", pending); else passCount++;
    cycles(1);
    checkCount++; if (pending !== 4'b0100) $display("[TB] FAIL single_pending: got %b want 0100", pending); else passCount++;
    checkCount++; if (intReq !== 1'b0) $display("[TB] FAIL single_req_early: got %b want 0", intReq); else passCount++;
    cycles(1);
    checkCount++; if (intReq !== 1'b1) $display("[TB] FAIL single_req: got %b want 1", intReq); else passCount++;
    checkCount++; if (vec !== 10'h3D0) $display("[TB] FAIL single_vec: got %h want 3d0", vec); else passCount++;
    pulseAck();
    checkCount++; if (pending !== 4'b0000) $display("[TB] FAIL single_ack_pending: got %b want 0000", pending); else passCount++;
    checkCount++; if (inService !== 4'b0100) $display("[TB] FAIL single_in_service: got %b want 0100", inService); else passCount++;
    checkCount++; if (intReq !== 1'b0) $display("[TB] FAIL single_ack_req: got %b want 0", intReq); else passCount++;
    pulseReti();
    checkCount++; if (inService !== 4'b0000) $display("[TB] FAIL single_reti: got %b want 0000", inService); else passCount++;
  endtask

  task automatic test_priority();
    pulseIrq(4'b1010);
    cycles(3);
    checkCount++; if (intReq !== 1'b1) $display("[TB] FAIL prio_req: got %b want 1", intReq); else passCount++;
    checkCount++; if (vec !== 10'h3C8) $display("[TB] FAIL prio_vec_first: got %h want 3c8", vec); else passCount++;
    pulseAck();
    checkCount++; if (pending !== 4'b1000) $display("[TB] FAIL prio_pending_left: got %b want 1000", pending); else passCount++;
    checkCount++; if (inService !== 4'b0010) $display("[TB] FAIL prio_in_service: got %b want 0010", inService); else passCount++;
    pulseReti();
    checkCount++; if (intReq !== 1'b0) $display("[TB] FAIL prio_gap: got %b want 0", intReq); else passCount++;
    cycles(1);
    checkCount++; if (intReq !== 1'b1) $display("[TB] FAIL prio_req_second: got %b want 1", intReq); else passCount++;
    checkCount++; if (vec !== 10'h3D8) $display("[TB] FAIL prio_vec_second: got %h want 3d8", vec); else passCount++;
    pulseAck();
    checkCount++; if (inService !== 4'b1000) $display("[TB] FAIL prio_in_service2: got %b want 1000", inService); else passCount++;
    pulseReti();
  endtask

  task automatic test_serv_accumulate();
    pulseIrq(4'b0100);
    cycles(3);
    pulseAck();
    pulseIrq(4'b0001);
    cycles(2);
    checkCount++; if (pending !== 4'b0001) $display("[TB] FAIL serv_pending: got %b want 0001", pending); else passCount++;
    cycles(2);
    checkCount++; if (intReq !== 1'b0) $display("[TB] FAIL serv_no_req: got %b want 0", intReq); else passCount++;
    int_ackOutsideReq();
    pulseReti();
    checkCount++; if (intReq !== 1'b0) $display("[TB] FAIL serv_reti_gap: got %b want 0", intReq); else passCount++;
    cycles(1);
    checkCount++; if (intReq !== 1'b1) $display("[TB] FAIL serv_req_after: got %b want 1", intReq); else passCount++;
    checkCount++; if (vec !== 10'h3C0) $display("[TB] FAIL serv_vec: got %h want 3c0", vec); else passCount++;
    pulseAck();
    pulseReti();
  endtask

  // Stray acknowledge while servicing must leave pending and in-service untouched.
  task automatic int_ackOutsideReq();
    pulseAck();
    checkCount++; if (pending !== 4'b0001) $display("[TB] FAIL stray_ack_pending: got %b want 0001", pending); else passCount++;
    checkCount++; if (inService !== 4'b0100) $display("[TB] FAIL stray_ack_in_service: got %b want 0100", inService); else passCount++;
  endtask

  task automatic test_di_withdraw();
    pulseIrq(4'b0010);
    cycles(3);
    checkCount++; if (vec !== 10'h3C8) $display("[TB] FAIL di_vec_first: got %h want 3c8", vec); else passCount++;
    di = 1'b1; cycles(1); di = 1'b0;
    checkCount++; if (intReq !== 1'b0) $display("[TB] FAIL di_withdraw: got %b want 0", intReq); else passCount++;
    checkCount++; if (pending !== 4'b0010) $display("[TB] FAIL di_pending_kept: got %b want 0010", pending); else passCount++;
    checkCount++; if (ie !== 1'b0) $display("[TB] FAIL di_ie: got %b want 0", ie); else passCount++;
    ei = 1'b1; di = 1'b1; cycles(1); ei = 1'b0; di = 1'b0;
    checkCount++; if (ie !== 1'b0) $display("[TB] FAIL ei_di_together: got %b want 0", ie); else passCount++;
    ei = 1'b1; cycles(1); ei = 1'b0;
    checkCount++; if (intReq !== 1'b0) $display("[TB] FAIL ei_req_latency: got %b want 0", intReq); else passCount++;
    cycles(1);
    checkCount++; if (intReq !== 1'b1) $display("[TB] FAIL ei_reraise: got %b want 1", intReq); else passCount++;
    checkCount++; if (vec !== 10'h3C8) $display("[TB] FAIL ei_vec: got %h want 3c8", vec); else passCount++;
    di = 1'b1; intAck = 1'b1; cycles(1); di = 1'b0; intAck = 1'b0;
    checkCount++; if (inService !== 4'b0010) $display("[TB] FAIL di_ack_in_service: got %b want 0010", inService); else passCount++;
    checkCount++; if (pending !== 4'b0000) $display("[TB] FAIL di_ack_pending: got %b want 0000", pending); else passCount++;
    checkCount++; if (ie !== 1'b0) $display("[TB] FAIL di_ack_ie: got %b want 0", ie); else passCount++;
    pulseReti();
    ei = 1'b1; cycles(1); ei = 1'b0;
  endtask

  task automatic test_mask();
    maskWe = 1'b1; maskDin = 4'b0000; cycles(1); maskWe = 1'b0;
    pulseIrq(4'b0100);
    cycles(3);
    checkCount++; if (pending !== 4'b0100) $display("[TB] FAIL mask_pending: got %b want 0100", pending); else passCount++;
    checkCount++; if (intReq !== 1'b0) $display("[TB] FAIL mask_blocked: got %b want 0", intReq); else passCount++;
    maskWe = 1'b1; maskDin = 4'b0100; cycles(1); maskWe = 1'b0;
    checkCount++; if (intReq !== 1'b0) $display("[TB] FAIL mask_latency: got %b want 0", intReq); else passCount++;
    cycles(1);
    checkCount++; if (intReq !== 1'b1) $display("[TB] FAIL mask_req: got %b want 1", intReq); else passCount++;
    checkCount++; if (vec !== 10'h3D0) $display("[TB] FAIL mask_vec: got %h want 3d0", vec); else passCount++;
    pulseAck();
    pulseReti();
    maskWe = 1'b1; maskDin = 4'b1111; cycles(1); maskWe = 1'b0;
  endtask

  task automatic test_level_held();
    irq = 4'b1000;
    cycles(3);
    checkCount++; if (pending !== 4'b1000) $display("[TB] FAIL level_pending: got %b want 1000", pending); else passCount++;
    cycles(1);
    pulseAck();
    cycles(4);
    checkCount++; if (pending !== 4'b0000) $display("[TB] FAIL level_single_edge: got %b want 0000", pending); else passCount++;
    checkCount++; if (inService !== 4'b1000) $display("[TB] FAIL level_in_service: got %b want 1000", inService); else passCount++;
    irq = 4'b0000;
    // Leave the controller in SERV for the asynchronous reset test.
  endtask

  task automatic test_reset_mid_serv();
    #2 rstN = 1'b0;
    #1;
    checkCount++; if (inService !== 4'b0000) $display("[TB] FAIL async_in_service: got %b want 0000", inService); else passCount++;
    checkCount++; if (ie !== 1'b0) $display("[TB] FAIL async_ie: got %b want 0", ie); else passCount++;
    checkCount++; if (vec !== 10'h3C0) $display("[TB] FAIL async_vec: got %h want 3c0", vec); else passCount++;
    checkCount++; if (intReq !== 1'b0) $display("[TB] FAIL async_int_req: got %b want 0", intReq); else passCount++;
    irq = 4'b0001;
    cycles(2);
    rstN = 1'b1;
    cycles(2);
    checkCount++; if (pending !== 4'b0000) $display("[TB] FAIL release_pending_early: got %b want 0000", pending); else passCount++;
    cycles(1);
    checkCount++; if (pending !== 4'b0001) $display("[TB] FAIL release_edge: got %b want 0001", pending); else passCount++;
    cycles(1);
    checkCount++; if (intReq !== 1'b0) $display("[TB] FAIL release_masked: got %b want 0", intReq); else passCount++;
    irq = 4'b0000;
  endtask

  initial begin
    rstN = 1'b0; irq = 4'b0000; ei = 1'b0; di = 1'b0;
    maskWe = 1'b0; maskDin = 4'b0000; intAck = 1'b0; reti = 1'b0;
    cycles(2);
    test_reset();
    rstN = 1'b1;
    cycles(1);
    test_single();
    test_priority();
    test_serv_accumulate();
    test_di_withdraw();
    test_mask();
    test_level_held();
    test_reset_mid_serv();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
